exu_mul_issue_ctrl: RTL and testbench
=====================================

Name: exu_mul_issue_ctrl

Overview:
- Initiator-side controller for the slow booth multiplier.
- Sits in the EXU between the decode/issue stage and the multiplier's valid/ready port.
- Accepts one RV64M multiply request, drives the multiplier with held operands and signedness, and captures the 128-bit product on the ready pulse.
- Selects and sign-extends the architectural 64-bit result, presents it to writeback with backpressure, and supports pipeline flush (abort) at any point.

Parameters:
- XLEN, 64, operand and result width; the multiplier product is 2*XLEN.
- ABORT_CYCLES, 2, minimum cycles mul_valid_o is held low after an abort before a new issue is allowed (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  issue-stage request valid
- req_ready_o  out  1  controller can accept a request
- req_op_i  in  3  0=MUL 1=MULH 2=MULHSU 3=MULHU 4=MULW; 5-7 reserved
- req_rs1_i  in  XLEN  operand 1
- req_rs2_i  in  XLEN  operand 2
- flush_i  in  1  pipeline flush; kills any in-flight or pending request
- resp_valid_o  out  1  result valid to writeback
- resp_data_o  out  XLEN  result
- resp_ready_i  in  1  writeback accepts result
- busy_o  out  1  state != IDLE
- mul_valid_o  out  1  request to multiplier; must stay high for the whole operation
- mul_rs1_signed_o  out  1  rs1 signedness
- mul_rs2_signed_o  out  1  rs2 signedness
- mul_rs1_data_o  out  XLEN  operand 1 to multiplier
- mul_rs2_data_o  out  XLEN  operand 2 to multiplier
- mul_ready_i  in  1  one-cycle completion pulse from multiplier
- mul_out_i  in  2*XLEN  product; valid in the cycle mul_ready_i=1

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, on rst.
  - Reset values: state=IDLE; all registered outputs and operand/result registers are 0.
  - Therefore req_ready_o=1, resp_valid_o=0, mul_valid_o=0 and busy_o=0 the cycle after rst.
- States: IDLE, BUSY, RESP, ABORT.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i && !flush_i: latch op and operands, then go to BUSY.
  - Reserved op values are accepted and treated as MUL.
- Signedness:
  - MUL, MULH, MULW: both signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: both unsigned.
- Operand outputs: mul_* operand and signedness outputs are driven from registers and are stable from BUSY entry until the next accept.
- BUSY:
  - mul_valid_o = !mul_ready_i && !flush_i. This is a combinational gate, so valid is already low in the ready-pulse cycle and the multiplier does not restart from its idle state.
  - On mul_ready_i && !flush_i: register the result and go to RESP.
  - Result selection:
    - MUL: product[63:0].
    - MULH, MULHSU, MULHU: product[127:64].
    - MULW: sign-extension of product[31:0].
- RESP:
  - resp_valid_o=1 and resp_data_o is held stable until resp_ready_i.
  - On handshake go to IDLE; a new request is accepted no earlier than the next cycle.
- ABORT:
  - mul_valid_o=0 for ABORT_CYCLES cycles (counter), then go to IDLE.
  - This guarantees the multiplier observes a dropped valid and returns to its idle state.
- Flush:
  - BUSY: go to ABORT. This includes the case where mul_ready_i arrives in the same cycle; the product is discarded.
  - RESP: drop resp_valid_o next cycle and go to IDLE without a handshake.
  - IDLE: flush wins over req_valid_i and the request is not accepted.
  - ABORT: restart the abort counter.
- mul_ready_i outside BUSY is ignored; no state change.
- No timeout: BUSY waits indefinitely for mul_ready_i.
- Latency: accept-to-resp_valid_o = multiplier latency + 1 cycle.

Test Plan:
- Reset: hold rst 3 cycles with random inputs -> req_ready_o=1, resp_valid_o=0, mul_valid_o=0, busy_o=0 after release.
- Basic ops (bench multiplier model, ready after 36 cycles):
  - MUL 3 * 0xFFFFFFFFFFFFFFFE -> 0xFFFFFFFFFFFFFFFA.
  - MULHU all-ones * all-ones -> 0xFFFFFFFFFFFFFFFE.
  - MULH all-ones * all-ones -> 0.
  - MULHSU all-ones * all-ones -> 0xFFFFFFFFFFFFFFFF.
  - MULW 0x7FFFFFFF * 2 -> 0xFFFFFFFFFFFFFFFE.
  - Check signedness pins for each op.
- Protocol: across the whole operation, mul_valid_o stays high continuously from the cycle after accept until the ready-pulse cycle, where it is 0, and the model sees no re-trigger.
- Backpressure: hold resp_ready_i=0 for 5 cycles after resp_valid_o -> data stable, req_ready_o=0. Then raise it -> IDLE next cycle.
- Flush mid-BUSY at cycle 10 -> mul_valid_o low >=2 cycles, no resp_valid_o; a new MUL 5*7 -> 35.
- Corner cases:
  - flush_i coincident with mul_ready_i -> no response.
  - flush_i coincident with req_valid_i in IDLE -> not accepted.
  - flush_i in RESP -> resp_valid_o drops next cycle.

Source files
------------

// File: rtl/exu_mul_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : exu_mul_issue_ctrl_if
//  Description : Bundle of the issue-side, writeback-side and multiplier-side
//                signals of the EXU multiply issue controller.
//                The slave modport is the controller's view. The master
//                modport is the surrounding pipeline and multiplier.
//  Ports       : req_*   issue request (valid/ready, op, operands)
//                flush_i pipeline flush
//                resp_*  writeback response (valid/ready, data)
//                busy_o  controller not idle
//                mul_*   booth multiplier valid/ready port, operands, product
//  Revision    : 1.0 - initial release
// ============================================================================
interface exu_mul_issue_ctrl_if #(
    parameter int XLEN = 64
);
    // Issue stage
    logic                req_valid_i;
    logic                req_ready_o;
    logic [2:0]          req_op_i;
    logic [XLEN-1:0]     req_rs1_i;
    logic [XLEN-1:0]     req_rs2_i;
    logic                flush_i;

    // Writeback
    logic                resp_valid_o;
    logic [XLEN-1:0]     resp_data_o;
    logic                resp_ready_i;
    logic                busy_o;

    // Multiplier
    logic                mul_valid_o;
    logic                mul_rs1_signed_o;
    logic                mul_rs2_signed_o;
    logic [XLEN-1:0]     mul_rs1_data_o;
    logic [XLEN-1:0]     mul_rs2_data_o;
    logic                mul_ready_i;
    logic [2*XLEN-1:0]   mul_out_i;

    // Controller side
    modport slave (
        input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i, flush_i,
        input  resp_ready_i, mul_ready_i, mul_out_i,
        output req_ready_o, resp_valid_o, resp_data_o, busy_o,
        output mul_valid_o, mul_rs1_signed_o, mul_rs2_signed_o,
        output mul_rs1_data_o, mul_rs2_data_o
    );

    // Pipeline / multiplier side
    modport master (
        output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, flush_i,
        output resp_ready_i, mul_ready_i, mul_out_i,
        input  req_ready_o, resp_valid_o, resp_data_o, busy_o,
        input  mul_valid_o, mul_rs1_signed_o, mul_rs2_signed_o,
        input  mul_rs1_data_o, mul_rs2_data_o
    );
endinterface
`default_nettype wire

// File: rtl/exu_mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : exu_mul_issue_ctrl
//  Description : Initiator-side controller for the slow booth multiplier.
//                Accepts one RV64M multiply request from issue. It holds the
//                operands and signedness towards the multiplier and captures
//                the 2*XLEN product on the one-cycle ready pulse. It then
//                selects and sign-extends the architectural result. Finally
//                it presents the result to writeback with backpressure.
//                A flush aborts the operation at any point.
//  Ports       : clk, rst             clock, synchronous active-high reset
//                bus (slave modport)  issue request, flush, writeback
//                                     response, busy, multiplier port
//  Parameters  : XLEN          operand/result width (product is 2*XLEN)
//                ABORT_CYCLES  cycles mul_valid_o is held low after an abort
//                              before a new issue is allowed (>= 1)
//  Revision    : 1.0 - initial release
// ============================================================================
module exu_mul_issue_ctrl #(
    parameter int XLEN         = 64,
    parameter int ABORT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    exu_mul_issue_ctrl_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_OP_MUL    = 3'd0;
    localparam logic [2:0] c_OP_MULH   = 3'd1;
    localparam logic [2:0] c_OP_MULHSU = 3'd2;
    localparam logic [2:0] c_OP_MULHU  = 3'd3;
    localparam logic [2:0] c_OP_MULW   = 3'd4;

    // Result selection, decoded once at accept time
    localparam logic [1:0] c_SEL_LO    = 2'd0;  // product[XLEN-1:0]
    localparam logic [1:0] c_SEL_HI    = 2'd1;  // product[2*XLEN-1:XLEN]
    localparam logic [1:0] c_SEL_WORD  = 2'd2;  // sign-extended product[31:0]

    localparam int c_WORD_W = 32;

    // The counter holds the remaining abort cycles minus one, so it only
    // needs to represent 0 .. ABORT_CYCLES-1.
    localparam int                 c_CNT_W      = $clog2(ABORT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_ABORT_LOAD = c_CNT_W'(ABORT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_RESP  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_abort_cnt;

    // Operand / result registers
    logic [XLEN-1:0]      r_rs1;
    logic [XLEN-1:0]      r_rs2;
    logic                 r_rs1_signed;
    logic                 r_rs2_signed;
    logic [1:0]           r_res_sel;
    logic [XLEN-1:0]      r_resp_data;

    // ------------------------------------------------------------------------
    // Request decode (combinational, consumed only on accept)
    // ------------------------------------------------------------------------
    logic                 w_rs1_signed;
    logic                 w_rs2_signed;
    logic [1:0]           w_res_sel;
    logic                 w_accept;

    always_comb begin
        // Reserved encodings fall into the MUL defaults
        w_rs1_signed = 1'b1;
        w_rs2_signed = 1'b1;
        w_res_sel    = c_SEL_LO;
        case (bus.req_op_i)
            c_OP_MUL: begin
                w_rs1_signed = 1'b1;
                w_rs2_signed = 1'b1;
                w_res_sel    = c_SEL_LO;
            end
            c_OP_MULH: begin
                w_rs1_signed = 1'b1;
                w_rs2_signed = 1'b1;
                w_res_sel    = c_SEL_HI;
            end
            c_OP_MULHSU: begin
                w_rs1_signed = 1'b1;
                w_rs2_signed = 1'b0;
                w_res_sel    = c_SEL_HI;
            end
            c_OP_MULHU: begin
                w_rs1_signed = 1'b0;
                w_rs2_signed = 1'b0;
                w_res_sel    = c_SEL_HI;
            end
            c_OP_MULW: begin
                w_rs1_signed = 1'b1;
                w_rs2_signed = 1'b1;
                w_res_sel    = c_SEL_WORD;
            end
            default: begin
                w_rs1_signed = 1'b1;
                w_rs2_signed = 1'b1;
                w_res_sel    = c_SEL_LO;
            end
        endcase
    end

    // Flush has priority over a new request in IDLE
    assign w_accept = (r_state == S_IDLE) && bus.req_valid_i && !bus.flush_i;

    // ------------------------------------------------------------------------
    // Result selection from the product (valid in the ready-pulse cycle)
    // ------------------------------------------------------------------------
    logic [XLEN-1:0]      w_result;

    always_comb begin
        w_result = bus.mul_out_i[XLEN-1:0];
        case (r_res_sel)
            c_SEL_LO:   w_result = bus.mul_out_i[XLEN-1:0];
            c_SEL_HI:   w_result = bus.mul_out_i[2*XLEN-1:XLEN];
            c_SEL_WORD: w_result = {{(XLEN-c_WORD_W){bus.mul_out_i[c_WORD_W-1]}},
                                    bus.mul_out_i[c_WORD_W-1:0]};
            default:    w_result = bus.mul_out_i[XLEN-1:0];
        endcase
    end

    // ------------------------------------------------------------------------
    // Control state machine and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_abort_cnt  <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rs1_signed <= 1'b0;
            r_rs2_signed <= 1'b0;
            r_res_sel    <= c_SEL_LO;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Operands are loaded only here, so they stay stable
                    // towards the multiplier until the next accept.
                    if (w_accept) begin
                        r_rs1        <= bus.req_rs1_i;
                        r_rs2        <= bus.req_rs2_i;
                        r_rs1_signed <= w_rs1_signed;
                        r_rs2_signed <= w_rs2_signed;
                        r_res_sel    <= w_res_sel;
                        r_state      <= S_BUSY;
                    end
                end

                S_BUSY: begin
                    // A flush coinciding with the ready pulse still aborts.
                    // The product is dropped.
                    if (bus.flush_i) begin
                        r_abort_cnt <= c_ABORT_LOAD;
                        r_state     <= S_ABORT;
                    end else if (bus.mul_ready_i) begin
                        r_resp_data <= w_result;
                        r_state     <= S_RESP;
                    end
                end

                S_RESP: begin
                    // Flush retires the response without a handshake
                    if (bus.flush_i || bus.resp_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end

                S_ABORT: begin
                    // Keep valid low long enough for the multiplier to see
                    // the drop. A repeated flush restarts the wait.
                    if (bus.flush_i) begin
                        r_abort_cnt <= c_ABORT_LOAD;
                    end else if (r_abort_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_abort_cnt <= r_abort_cnt - c_CNT_ONE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.req_ready_o  = (r_state == S_IDLE);
    assign bus.busy_o       = (r_state != S_IDLE);
    assign bus.resp_valid_o = (r_state == S_RESP);
    assign bus.resp_data_o  = r_resp_data;

    // Valid is gated by the ready pulse in the same cycle. The multiplier
    // therefore never sees valid high while it is returning to idle, and it
    // cannot restart on a stale request. The flush gate drops valid
    // immediately on abort.
    assign bus.mul_valid_o      = (r_state == S_BUSY) && !bus.mul_ready_i && !bus.flush_i;
    assign bus.mul_rs1_signed_o = r_rs1_signed;
    assign bus.mul_rs2_signed_o = r_rs2_signed;
    assign bus.mul_rs1_data_o   = r_rs1;
    assign bus.mul_rs2_data_o   = r_rs2;

endmodule
`default_nettype wire

// File: tb/tb_exu_mul_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_exu_mul_issue_ctrl
//  Description : Self-checking bench for exu_mul_issue_ctrl with a multiplier
//                responder, a transaction-level reference model and directed
//                plus randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exu_mul_issue_ctrl;

    localparam int XLEN         = 64;
    localparam int ABORT_CYCLES = 2;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_MULW   = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exu_mul_issue_ctrl_if #(.XLEN(XLEN)) bus ();

    exu_mul_issue_ctrl #(
        .XLEN         (XLEN),
        .ABORT_CYCLES (ABORT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Architectural result from the RV64M definitions
    // ------------------------------------------------------------------------
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a,
                                               input logic [63:0] b);
        logic signed [127:0] sa, sb;
        logic        [127:0] ua, ub, p;
        logic        [31:0]  w;
        sa = $signed(a);
        sb = $signed(b);
        ua = {64'd0, a};
        ub = {64'd0, b};
        p  = '0;
        w  = '0;
        case (op)
            OP_MULH:   begin p = sa * sb;          return p[127:64]; end
            OP_MULHSU: begin p = sa * $signed(ub); return p[127:64]; end
            OP_MULHU:  begin p = ua * ub;          return p[127:64]; end
            OP_MULW:   begin w = a[31:0] * b[31:0]; return {{32{w[31]}}, w}; end
            default:   return a * b;
        endcase
    endfunction

    function automatic logic [1:0] ref_signs(input logic [2:0] op);
        case (op)
            OP_MULHSU: return 2'b10;
            OP_MULHU:  return 2'b00;
            default:   return 2'b11;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Slow multiplier responder: starts on valid, pulses ready m_lat+1 cycles
    // later, goes idle if valid drops mid-operation.
    // ------------------------------------------------------------------------
    logic         m_ready = 1'b0;
    logic         spur    = 1'b0;
    logic [127:0] m_out   = '0;
    logic         m_busy  = 1'b0;
    int           m_cnt   = 0;
    int           m_lat   = 36;
    int           retrig  = 0;
    logic [127:0] m_a = '0, m_b = '0;

    assign bus.mul_ready_i = m_ready | spur;
    assign bus.mul_out_i   = m_out;

    always @(posedge clk) begin
        if (rst) begin
            m_ready <= 1'b0;
            m_busy  <= 1'b0;
        end else if (m_ready) begin
            m_ready <= 1'b0;
            m_busy  <= 1'b0;
            if (bus.mul_valid_o) retrig <= retrig + 1;
        end else if (m_busy) begin
            if (!bus.mul_valid_o) begin
                m_busy <= 1'b0;
            end else if (m_cnt <= 1) begin
                m_ready <= 1'b1;
                m_out   <= m_a * m_b;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (bus.mul_valid_o) begin
            m_busy <= 1'b1;
            m_cnt  <= m_lat;
            m_a    <= bus.mul_rs1_signed_o ? {{64{bus.mul_rs1_data_o[63]}}, bus.mul_rs1_data_o}
                                           : {64'd0, bus.mul_rs1_data_o};
            m_b    <= bus.mul_rs2_signed_o ? {{64{bus.mul_rs2_data_o[63]}}, bus.mul_rs2_data_o}
                                           : {64'd0, bus.mul_rs2_data_o};
        end
    end

    // ------------------------------------------------------------------------
    // Reference model: an operation in flight, a held response, or a quiet
    // window measured in cycle numbers after an abort.
    // ------------------------------------------------------------------------
    int          cyc       = 0;
    int          quiet_end = 0;
    logic        in_op     = 1'b0;
    logic        holding   = 1'b0;
    logic        mdl_ok    = 1'b0;
    logic [2:0]  t_op  = '0;
    logic [63:0] t_a   = '0, t_b = '0, t_res = '0;
    logic        idle_m;

    assign idle_m = !in_op && !holding && (cyc >= quiet_end);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            in_op     <= 1'b0;
            holding   <= 1'b0;
            quiet_end <= 0;
            mdl_ok    <= 1'b1;
        end else if (in_op) begin
            if (bus.flush_i) begin
                in_op     <= 1'b0;
                quiet_end <= cyc + 1 + ABORT_CYCLES;
            end else if (bus.mul_ready_i) begin
                in_op   <= 1'b0;
                holding <= 1'b1;
                t_res   <= ref_result(t_op, t_a, t_b);
            end
        end else if (holding) begin
            if (bus.flush_i || bus.resp_ready_i) holding <= 1'b0;
        end else if (cyc < quiet_end) begin
            if (bus.flush_i) quiet_end <= cyc + 1 + ABORT_CYCLES;
        end else if (bus.req_valid_i && !bus.flush_i) begin
            in_op <= 1'b1;
            t_op  <= bus.req_op_i;
            t_a   <= bus.req_rs1_i;
            t_b   <= bus.req_rs2_i;
        end
    end

    // Compare process, away from the active edge
    always @(negedge clk) begin
        if (!rst && mdl_ok) begin
            check("req_ready", bus.req_ready_o, idle_m);
            check("busy", bus.busy_o, !idle_m);
            check("resp_valid", bus.resp_valid_o, holding);
            check("mul_valid", bus.mul_valid_o, in_op && !bus.mul_ready_i && !bus.flush_i);
            if (holding) check("resp_data", bus.resp_data_o, t_res);
            if (in_op) begin
                check("rs1_data", bus.mul_rs1_data_o, t_a);
                check("rs2_data", bus.mul_rs2_data_o, t_b);
                check("signs", {bus.mul_rs1_signed_o, bus.mul_rs2_signed_o}, ref_signs(t_op));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'h0;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h0000_0000_7FFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int k = 0;
        while (!bus.req_ready_o && k < 200) begin tick(); k++; end
        check("issue_wait_idle", bus.req_ready_o, 1'b1);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_rs1_i   = a;
        bus.req_rs2_i   = b;
        tick();
        bus.req_valid_i = 1'b0;
        bus.req_rs1_i   = {$urandom, $urandom};
        bus.req_rs2_i   = {$urandom, $urandom};
        bus.req_op_i    = 3'($urandom_range(0, 7));
        check("issue_accepted", bus.busy_o, 1'b1);
    endtask

    task automatic wait_resp(output int vcount, output logic got);
        int k = 0;
        vcount = 0;
        while (!bus.resp_valid_o && k < 200) begin
            if (bus.mul_valid_o) vcount++;
            tick();
            k++;
        end
        got = bus.resp_valid_o;
    endtask

    task automatic run_op(input string nm, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input logic [1:0] signs,
                          input int hold);
        int   vc;
        logic got;
        issue(op, a, b);
        check({nm, "_signs"}, {bus.mul_rs1_signed_o, bus.mul_rs2_signed_o}, signs);
        wait_resp(vc, got);
        check({nm, "_resp_seen"}, got, 1'b1);
        check({nm, "_valid_len"}, vc, m_lat + 1);
        check({nm, "_data"}, bus.resp_data_o, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({nm, "_hold_data"}, bus.resp_data_o, exp);
            check({nm, "_hold_ready"}, bus.req_ready_o, 1'b0);
            check({nm, "_hold_valid"}, bus.resp_valid_o, 1'b1);
        end
        bus.resp_ready_i = 1'b1;
        tick();
        bus.resp_ready_i = 1'b0;
        check({nm, "_back_idle"}, bus.req_ready_o, 1'b1);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int   k;
        int   vc;
        logic got;

        bus.req_valid_i  = 1'b0;
        bus.req_op_i     = '0;
        bus.req_rs1_i    = '0;
        bus.req_rs2_i    = '0;
        bus.flush_i      = 1'b0;
        bus.resp_ready_i = 1'b0;

        // Reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req_valid_i  = 1'($urandom_range(0, 1));
            bus.req_op_i     = 3'($urandom_range(0, 7));
            bus.req_rs1_i    = {$urandom, $urandom};
            bus.flush_i      = 1'($urandom_range(0, 1));
            bus.resp_ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        rst              = 1'b0;
        bus.req_valid_i  = 1'b0;
        bus.flush_i      = 1'b0;
        bus.resp_ready_i = 1'b0;
        check("rst_req_ready", bus.req_ready_o, 1'b1);
        check("rst_resp_valid", bus.resp_valid_o, 1'b0);
        check("rst_mul_valid", bus.mul_valid_o, 1'b0);
        check("rst_busy", bus.busy_o, 1'b0);

        // Stray ready pulse while idle is ignored
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("spur_idle", bus.req_ready_o, 1'b1);
        check("spur_busy", bus.busy_o, 1'b0);

        // Directed ops, multiplier latency 36; first one with backpressure
        m_lat = 36;
        run_op("mul", OP_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 2'b11, 5);
        run_op("mulhu", OP_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, 0);
        run_op("mulh", OP_MULH, '1, '1, 64'h0, 2'b11, 0);
        run_op("mulhsu", OP_MULHSU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 0);
        run_op("mulw", OP_MULW, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2'b11, 0);
        run_op("reserved", 3'd6, 64'd6, 64'd7, 64'd42, 2'b11, 0);

        // Flush at cycle 10 of BUSY
        issue(OP_MUL, 64'd9, 64'd9);
        repeat (9) tick();
        bus.flush_i = 1'b1;
        #1;
        check("flush_gates_valid", bus.mul_valid_o, 1'b0);
        tick();
        bus.flush_i = 1'b0;
        for (int i = 0; i < ABORT_CYCLES; i++) begin
            check("abort_mul_valid", bus.mul_valid_o, 1'b0);
            check("abort_resp_valid", bus.resp_valid_o, 1'b0);
            check("abort_no_accept", bus.req_ready_o, 1'b0);
            tick();
        end
        run_op("after_flush", OP_MUL, 64'd5, 64'd7, 64'd35, 2'b11, 0);

        // Flush coincident with the ready pulse
        m_lat = 4;
        issue(OP_MULHU, '1, 64'd3);
        k = 0;
        while (!bus.mul_ready_i && k < 50) begin tick(); k++; end
        check("coinc_ready_seen", bus.mul_ready_i, 1'b1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("coinc_no_resp", bus.resp_valid_o, 1'b0);
            tick();
        end

        // Flush coincident with a request in IDLE
        k = 0;
        while (!bus.req_ready_o && k < 50) begin tick(); k++; end
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = OP_MUL;
        bus.flush_i     = 1'b1;
        tick();
        bus.req_valid_i = 1'b0;
        bus.flush_i     = 1'b0;
        check("flush_req_not_busy", bus.busy_o, 1'b0);
        check("flush_req_ready", bus.req_ready_o, 1'b1);
        tick();
        check("flush_req_no_valid", bus.mul_valid_o, 1'b0);

        // Flush in RESP
        issue(OP_MUL, 64'd11, 64'd13);
        wait_resp(vc, got);
        check("resp_flush_seen", got, 1'b1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("resp_flush_valid", bus.resp_valid_o, 1'b0);
        check("resp_flush_idle", bus.req_ready_o, 1'b1);

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            m_lat            = $urandom_range(1, 6);
            bus.req_valid_i  = ($urandom_range(0, 9) < 7);
            bus.req_op_i     = 3'($urandom_range(0, 7));
            bus.req_rs1_i    = rand_operand();
            bus.req_rs2_i    = rand_operand();
            bus.flush_i      = ($urandom_range(0, 29) == 0);
            bus.resp_ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        bus.req_valid_i  = 1'b0;
        bus.flush_i      = 1'b0;
        bus.resp_ready_i = 1'b1;
        repeat (20) tick();

        check("no_retrigger", retrig, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
